// File: rtl/cnn_pkg.sv
// Shared dimensions, FSM state type and fixed coefficients for the CNN inference block.
package cnn_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IMG    = 8;
    localparam int unsigned KS     = 3;
    localparam int unsigned CONV   = 6;
    localparam int unsigned POOL   = 3;
    localparam int unsigned FC_N   = 9;
    localparam int unsigned IMG_N  = IMG * IMG;
    localparam int unsigned CONV_N = CONV * CONV;
    localparam int unsigned POOL_N = POOL * POOL;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_POOL,
        S_FC,
        S_DONE
    } state_t;

    // Vertical Sobel kernel, row-major.
    localparam logic signed [DATA_W-1:0] K_COEF [FC_N] = '{
        32'sd1, 32'sd2, 32'sd1,
        32'sd0, 32'sd0, 32'sd0,
        -32'sd1, -32'sd2, -32'sd1
    };

    // Fully connected neuron weights, one per pooled value.
    localparam logic signed [DATA_W-1:0] W_COEF [FC_N] = '{
        32'sd1, -32'sd1, 32'sd2, -32'sd2, 32'sd3, -32'sd3, 32'sd4, -32'sd4, 32'sd5
    };

    function automatic logic signed [DATA_W-1:0] max2(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cnn_dot9.sv
// 9-term signed dot product with 32-bit wrap on every product and sum.
// Ports: i_a, i_b - nine packed 32-bit signed operands each (term k at [32k+31:32k]);
//        o_dot_c   - combinational wrapped sum of products.
module cnn_dot9
    import cnn_pkg::*;
(
    input  logic [FC_N*DATA_W-1:0] i_a,
    input  logic [FC_N*DATA_W-1:0] i_b,
    output logic [DATA_W-1:0]      o_dot_c
);

    logic signed [DATA_W-1:0] w_acc;

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < FC_N; k++) begin
            w_acc = w_acc + $signed(i_a[k*DATA_W +: DATA_W]) * $signed(i_b[k*DATA_W +: DATA_W]);
        end
        o_dot_c = w_acc;
    end

endmodule

// File: rtl/cnn_infer_pipeline.sv
// Single-image CNN inference: 8x8 image -> 3x3 conv (6x6) -> 2x2 max-pool (3x3) -> 9-input FC.
// Ports: clk, rst (sync, active-high); start - begin run (accepted in IDLE/DONE);
//        img_flat - 64 packed signed pixels, latched on accepted start;
//        value - signed FC score, stable while done; done - result-ready level.
module cnn_infer_pipeline
    import cnn_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [64*DW-1:0] img_flat,
    output logic [DW-1:0]    value,
    output logic             done
);

    state_t r_state;
    state_t w_next;

    logic [5:0]               r_idx;
    logic signed [DATA_W-1:0] r_img  [IMG_N];
    logic signed [DATA_W-1:0] r_conv [CONV_N];
    logic signed [DATA_W-1:0] r_pool [POOL_N];

    logic [2:0]               w_crow, w_ccol;
    logic [2:0]               w_prow, w_pcol;
    logic [5:0]               w_pbase;
    logic signed [DATA_W-1:0] w_pool_max;
    logic [FC_N*DATA_W-1:0]   w_dot_a, w_dot_b;
    logic [DATA_W-1:0]        w_dot;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_CONV;
            S_CONV:         if (r_idx == 6'(CONV_N - 1)) w_next = S_POOL;
            S_POOL:         if (r_idx == 6'(POOL_N - 1)) w_next = S_FC;
            S_FC:           w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    // Map the flat index onto conv and pool coordinates.
    always_comb begin
        w_crow  = 3'(r_idx / 6'(CONV));
        w_ccol  = 3'(r_idx % 6'(CONV));
        w_prow  = 3'(r_idx / 6'(POOL));
        w_pcol  = 3'(r_idx % 6'(POOL));
        // Pool coordinates are only meaningful in POOL; keep the base in range otherwise.
        w_pbase = '0;
        if (r_state == S_POOL) begin
            w_pbase = 6'(int'(w_prow) * 2 * int'(CONV) + int'(w_pcol) * 2);
        end
    end

    // 2x2 signed max over the current pooling window.
    always_comb begin
        w_pool_max = max2(max2(r_conv[w_pbase],              r_conv[w_pbase + 6'd1]),
                          max2(r_conv[w_pbase + 6'(CONV)],   r_conv[w_pbase + 6'(CONV + 1)]));
    end

    // Shared dot-product operands: pool x W in FC, image window x K otherwise.
    always_comb begin
        w_dot_a = '0;
        w_dot_b = '0;
        for (int k = 0; k < FC_N; k++) begin
            if (r_state == S_FC) begin
                w_dot_a[k*DATA_W +: DATA_W] = r_pool[k];
                w_dot_b[k*DATA_W +: DATA_W] = W_COEF[k];
            end else begin
                w_dot_a[k*DATA_W +: DATA_W] =
                    r_img[6'((int'(w_crow) + k / int'(KS)) * int'(IMG) + int'(w_ccol) + k % int'(KS))];
                w_dot_b[k*DATA_W +: DATA_W] = K_COEF[k];
            end
        end
    end

    cnn_dot9 u_dot9 (
        .i_a     (w_dot_a),
        .i_b     (w_dot_b),
        .o_dot_c (w_dot)
    );

    // Datapath: image latch, conv/pool buffers, index counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            value <= '0;
            done  <= 1'b0;
            for (int k = 0; k < IMG_N; k++)  r_img[k]  <= '0;
            for (int k = 0; k < CONV_N; k++) r_conv[k] <= '0;
            for (int k = 0; k < POOL_N; k++) r_pool[k] <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        for (int k = 0; k < IMG_N; k++) r_img[k] <= img_flat[k*DATA_W +: DATA_W];
                        done  <= 1'b0;
                        r_idx <= '0;
                    end
                end
                S_CONV: begin
                    r_conv[r_idx] <= w_dot;
                    r_idx         <= (r_idx == 6'(CONV_N - 1)) ? 6'd0 : r_idx + 6'd1;
                end
                S_POOL: begin
                    r_pool[r_idx[3:0]] <= w_pool_max;
                    r_idx              <= r_idx + 6'd1;
                end
                S_FC: begin
                    value <= w_dot;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_infer_pipeline.sv
// Self-checking bench for cnn_infer_pipeline: directed and random images against an
// array-based reference model of conv -> max-pool -> FC.
module tb_cnn_infer_pipeline;
    import cnn_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2047:0] img;
    logic [31:0]   value;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int exp_pool [9];

    cnn_infer_pipeline #(.DW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .img_flat (img),
        .value    (value),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reference model; int arithmetic wraps at 32 bits just like the block.
    function automatic int model(input logic [2047:0] im);
        int kk [9] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
        int ww [9] = '{1, -1, 2, -2, 3, -3, 4, -4, 5};
        int px [64];
        int cv [36];
        int acc;
        int m;
        for (int k = 0; k < 64; k++) px[k] = im[k*32 +: 32];
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) begin
                acc = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += px[(r+i)*8 + c + j] * kk[i*3 + j];
                cv[r*6 + c] = acc;
            end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                m = cv[(2*r)*6 + 2*c];
                if (cv[(2*r)*6 + 2*c + 1] > m)   m = cv[(2*r)*6 + 2*c + 1];
                if (cv[(2*r+1)*6 + 2*c] > m)     m = cv[(2*r+1)*6 + 2*c];
                if (cv[(2*r+1)*6 + 2*c + 1] > m) m = cv[(2*r+1)*6 + 2*c + 1];
                exp_pool[r*3 + c] = m;
            end
        acc = 0;
        for (int i = 0; i < 9; i++) acc += exp_pool[i] * ww[i];
        return acc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic start_run(input logic [2047:0] im);
        @(negedge clk);
        img   = im;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done rises; bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_image(input string tag, input logic [2047:0] im);
        int n;
        int exp_v;
        exp_v = model(im);
        start_run(im);
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        wait_done(n);
        check({tag, "_latency"}, 32'(n), 32'd46);
        check({tag, "_value"}, value, 32'(exp_v));
    endtask

    logic [2047:0] im_a;
    logic [2047:0] im_b;
    int            n_lat;
    int            exp_a;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        img   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", 32'(done), 32'd0);
        check("reset_value", value, 32'd0);
        check("reset_state", 32'(dut.r_state), 32'(S_IDLE));
        @(negedge clk);
        rst = 1'b0;

        // All-zero image, then hold for 10 cycles.
        run_image("zero", '0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("zero_hold_done", 32'(done), 32'd1);
            check("zero_hold_value", value, 32'd0);
        end

        // Row ramp: every conv and pool is -8, score -40.
        for (int k = 0; k < 64; k++) im_a[k*32 +: 32] = 32'(k / 8);
        run_image("row_ramp", im_a);
        check("row_ramp_abs", value, -32'sd40);
        for (int i = 0; i < 9; i++) check("row_ramp_pool", dut.r_pool[i], -32'sd8);

        // Column ramp: horizontal gradient invisible to vertical Sobel.
        for (int k = 0; k < 64; k++) im_a[k*32 +: 32] = 32'(k % 8);
        run_image("col_ramp", im_a);
        check("col_ramp_abs", value, 32'd0);

        // Single positive and negative corner pixel.
        im_a = '0;
        im_a[31:0] = 32'd100;
        run_image("pix_pos", im_a);
        check("pix_pos_abs", value, 32'd100);
        check("pix_pos_pool0", dut.r_pool[0], 32'd100);
        im_a[31:0] = -32'sd100;
        run_image("pix_neg", im_a);
        check("pix_neg_abs", value, 32'd0);
        check("pix_neg_pool0", dut.r_pool[0], 32'd0);

        // Random images: small signed range, then full 32-bit with wrap.
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 64; k++) im_a[k*32 +: 32] = 32'($urandom_range(2000) - 1000);
            run_image("rand_small", im_a);
        end
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 64; k++) im_a[k*32 +: 32] = $urandom;
            run_image("rand_full", im_a);
        end
        exp_a = model(im_a);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rand_hold_value", value, 32'(exp_a));
        end

        // Start re-asserted mid-CONV with another image must be ignored.
        for (int k = 0; k < 64; k++) im_a[k*32 +: 32] = 32'($urandom_range(200) - 100);
        for (int k = 0; k < 64; k++) im_b[k*32 +: 32] = 32'($urandom_range(200) - 100);
        exp_a = model(im_a);
        start_run(im_a);
        repeat (10) @(posedge clk);
        @(negedge clk);
        img   = im_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n_lat);
        check("restart_latency", 32'(n_lat), 32'd35);
        check("restart_value", value, 32'(exp_a));

        // Reset in the middle of POOL aborts the second run.
        start_run(im_b);
        repeat (38) @(posedge clk);
        #1;
        check("mid_pool_state", 32'(dut.r_state), 32'(S_POOL));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_done", 32'(done), 32'd0);
        check("abort_value", value, 32'd0);
        check("abort_state", 32'(dut.r_state), 32'(S_IDLE));
        check("abort_pool0", dut.r_pool[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Restart after abort produces the right result.
        run_image("after_abort", im_b);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cnn_infer_pipeline.md
Name: cnn_infer_pipeline

Overview:
- Single-image CNN inference block: 8x8 signed 32-bit input image -> 3x3 valid convolution (6x6 map) -> 2x2/stride-2 max-pool (3x3 map) -> 9-input fully connected neuron -> one signed 32-bit score.
- Sits under the accelerator core controller. Started by a one-cycle start pulse; reports completion with a done level.

Parameters:
- DW, 32, pixel/weight/accumulator width (signed). Only 32 is required to be supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin inference; sampled only in IDLE or DONE
- img_flat  in  2048  64 signed pixels; pixel k = row*8+col at bits [32k+31:32k]; latched on accepted start
- value  out  32  signed FC result; stable while done=1
- done  out  1  high from result-ready until next accepted start or reset

Behaviour:
- Reset: state=IDLE, done=0, value=0, all internal buffers cleared. Reset mid-operation aborts immediately, with the same values.
- States: IDLE, CONV, POOL, FC, DONE.
- IDLE/DONE + start=1:
  - Latch img_flat into a 64-entry image buffer.
  - done<=0, idx<=0, go to CONV.
  - start in any other state is ignored, and img_flat changes mid-run have no effect.
- CONV:
  - One output per cycle, idx 0..35, r=idx/6, c=idx%6.
  - conv[idx] = sum over i,j in 0..2 of img[(r+i)*8+c+j]*K[i*3+j].
  - After idx=35: idx<=0, go to POOL (36 cycles).
- POOL:
  - One output per cycle, idx 0..8, r=idx/3, c=idx%3.
  - pool[idx] = signed max of conv[(2r)*6+2c], conv[(2r)*6+2c+1], conv[(2r+1)*6+2c], conv[(2r+1)*6+2c+1].
  - After idx=8, go to FC (9 cycles).
- FC (1 cycle):
  - value <= sum over i of pool[i]*W[i].
  - done<=1, go to DONE.
- Latency: start accepted at edge E0 -> done=1 and value valid after edge E46.
- DONE: value and done hold until an accepted start or rst.
- Arithmetic:
  - Signed two's complement.
  - Each product and each sum is truncated to 32 bits (wrap-around, no saturation).
  - No bias, no activation function.
- Constants:
  - K = {1,2,1, 0,0,0, -1,-2,-1} (row-major; vertical Sobel).
  - W = {1,-1,2,-2,3,-3,4,-4,5}.

Decomposition:
- Package cnn_pkg holds:
  - Dimension constants: IMG=8, KS=3, CONV=6, POOL=3, FC_N=9.
  - The state enum.
  - The K and W constant arrays.
- One combinational sub-module, cnn_dot9: a 9-term signed 32-bit dot product with wrap. It is shared by CONV (window x K) and FC (pool x W).
- The 2x2 max stays inline.

Test Plan:
- All-zero image, start pulse -> done rises exactly 46 cycles after the start edge, value=0; done and value hold for 10 further cycles.
- Row-ramp image (pixel = row index), start -> every conv=-8, every pool=-8, value=-40.
- Column-ramp image (pixel = col index) -> all conv=0, value=0.
- Single pixel img[0]=100, others 0 -> conv[0]=100, pool[0]=100, value=100.
- Single pixel img[0]=-100, others 0 -> pool[0]=0 (signed max against zeros), value=0.
- Start re-asserted mid-CONV with a different image -> ignored, result equals the first image's. Then rst asserted mid-POOL of a second run -> next cycle done=0, value=0, state IDLE. Then a restart -> correct result.
